// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard/sequencing control logic.
//   state_t     : sequencer FSM states (RUN, MEM_WAIT, TRAP)
//   REG_ADDR_W  : width of a register-file address field
//   BUBBLE_CTRL : control-bit pattern a flushed pipeline register loads
package pipeline_pkg;

  localparam int REG_ADDR_W = 5;

  // A flushed pipeline register loads all control bits as zero, which turns
  // the slot into a no-op that writes nothing and touches no memory.
  localparam logic [7:0] BUBBLE_CTRL = 8'h00;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TRAP     = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare (purely combinational).
// Ports:
//   id_rs, id_rt  : source register fields of the instruction in ID
//   ex_mem_read   : instruction in EX is a load
//   ex_rt_or_rd   : destination register of the instruction in EX
//   load_use      : ID needs the value the EX load has not produced yet
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt_or_rd,
  output logic                  load_use
);

  // $zero is never a real dependency, so a load targeting it cannot stall.
  assign load_use = ex_mem_read
                  && (ex_rt_or_rd != '0)
                  && ((ex_rt_or_rd == id_rs) || (ex_rt_or_rd == id_rt));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central sequencer for the 5-stage pipeline: generates PC / pipeline
// register enables and flushes, resolves taken branches at MEM, stalls on
// load-use, freezes the whole pipeline during multi-cycle data-memory
// accesses and traps (sticky) on a memory timeout.
// Parameters: TIMEOUT (max MEM_WAIT cycles, 1..65535), CNT_W (perf width).
// Ports:
//   clk, rst_n                       : clock, async active-low reset
//   id_rs, id_rt, ex_mem_read,
//   ex_rt_or_rd                      : load-use compare inputs
//   mem_branch, mem_zero             : branch resolution from EX/MEM
//   mem_mem_read, mem_mem_write      : data-memory access in MEM
//   dmem_ready / dmem_req            : data-memory handshake
//   *_en / *_flush                   : register enables / bubble loads
//   pc_sel_branch                    : PC takes branch target
//   trap                             : sticky memory-timeout error
//   fsm_state                        : current sequencer state (debug)
// Handshake: dmem_req is held high for as long as the access in MEM is
// outstanding; the access completes in the cycle dmem_ready is high while
// dmem_req is high. dmem_ready with dmem_req low is ignored.
// Optional: define HAZARD_PERF_CNT_EN to add the stall_cycles,
// flush_events and loaduse_events saturating performance counters.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt_or_rd,
  input  logic                  mem_branch,
  input  logic                  mem_zero,
  input  logic                  mem_mem_read,
  input  logic                  mem_mem_write,
  input  logic                  dmem_ready,
  output logic                  dmem_req,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic                  mem_wb_flush,
  output logic                  pc_sel_branch,
  output logic                  trap,
  output logic [1:0]            fsm_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events,
  output logic [CNT_W-1:0]      loaduse_events
`endif
);

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] wait_cnt;
  logic        trap_q;

  logic load_use;
  logic mem_acc;
  logic active;
  logic acc_done;
  logic freeze;
  logic advance;
  logic taken;
  logic lu_stall;

  hazard_detect u_hazard_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rt_or_rd (ex_rt_or_rd),
    .load_use    (load_use)
  );

  assign mem_acc  = mem_mem_read | mem_mem_write;
  assign active   = (state != TRAP);
  assign acc_done = mem_acc & dmem_ready;

  // Freeze: any outstanding access that has not completed this cycle.
  assign freeze   = active & mem_acc & ~dmem_ready;
  assign advance  = active & ~freeze;
  // Branch beats load-use: the flush already kills the dependent instruction.
  assign taken    = advance & mem_branch & mem_zero;
  assign lu_stall = advance & ~taken & load_use;

  // rst_n gating makes the request drop the instant reset asserts, even
  // while the MEM-stage inputs still describe the abandoned access.
  assign dmem_req      = rst_n & active & mem_acc;

  assign pc_en         = advance & ~lu_stall;
  assign if_id_en      = advance & ~lu_stall;
  assign id_ex_en      = advance;
  assign ex_mem_en     = advance;
  assign mem_wb_en     = advance;
  assign if_id_flush   = taken;
  assign id_ex_flush   = taken | lu_stall;
  assign ex_mem_flush  = taken;
  assign mem_wb_flush  = 1'b0;
  assign pc_sel_branch = taken;
  assign trap          = trap_q;
  assign fsm_state     = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
      trap_q   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_acc && !dmem_ready) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (acc_done) begin
            state <= RUN;
          end else if (wait_cnt == WAIT_LAST) begin
            // wait_cnt counts completed wait cycles minus one, so this is
            // the TIMEOUT-th wait cycle without completion.
            state  <= TRAP;
            trap_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        TRAP: begin
          trap_q <= 1'b1;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // In TRAP freeze/taken/lu_stall are all 0, so the counters hold there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles   <= '0;
      flush_events   <= '0;
      loaduse_events <= '0;
    end else begin
      if (freeze && stall_cycles != CNT_MAX)
        stall_cycles <= stall_cycles + 1'b1;
      if (taken && flush_events != CNT_MAX)
        flush_events <= flush_events + 1'b1;
      if (lu_stall && loaduse_events != CNT_MAX)
        loaduse_events <= loaduse_events + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (TIMEOUT = 4).
module tb_pipeline_hazard_ctrl;
  import pipeline_pkg::*;

  localparam int TO = 4;

  // Control vector layout:
  // {pc_en,if_id_en,id_ex_en,ex_mem_en,mem_wb_en,
  //  if_id_flush,id_ex_flush,ex_mem_flush,mem_wb_flush,
  //  pc_sel_branch,dmem_req,trap}
  localparam logic [11:0] C_NORMAL = 12'b11111_0000_0_0_0;
  localparam logic [11:0] C_MEMADV = 12'b11111_0000_0_1_0;
  localparam logic [11:0] C_FREEZE = 12'b00000_0000_0_1_0;
  localparam logic [11:0] C_LDUSE  = 12'b00111_0100_0_0_0;
  localparam logic [11:0] C_BRANCH = 12'b11111_1110_1_0_0;
  localparam logic [11:0] C_BR_MEM = 12'b11111_1110_1_1_0;
  localparam logic [11:0] C_TRAP   = 12'b00000_0000_0_0_1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt_or_rd = '0;
  logic       ex_mem_read = 0, mem_branch = 0, mem_zero = 0;
  logic       mem_mem_read = 0, mem_mem_write = 0, dmem_ready = 0;
  logic       dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic       pc_sel_branch, trap;
  logic [1:0] fsm_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events, loaduse_events;
`endif

  logic [11:0] ctl;
  assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
                pc_sel_branch, dmem_req, trap};

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .ex_mem_read(ex_mem_read),
    .ex_rt_or_rd(ex_rt_or_rd), .mem_branch(mem_branch), .mem_zero(mem_zero),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .dmem_ready(dmem_ready), .dmem_req(dmem_req),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .pc_sel_branch(pc_sel_branch), .trap(trap), .fsm_state(fsm_state)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events),
    .loaduse_events(loaduse_events)
`endif
  );

  // clock
  always #5 clk = ~clk;

  // driver: apply one cycle's inputs just after the falling edge, then
  // settle 1 time unit so combinational outputs can be sampled.
  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic exr, input logic [4:0] exd,
                       input logic br, input logic z,
                       input logic mr, input logic mw, input logic rdy);
    @(negedge clk);
    id_rs = rs; id_rt = rt; ex_mem_read = exr; ex_rt_or_rd = exd;
    mem_branch = br; mem_zero = z;
    mem_mem_read = mr; mem_mem_write = mw; dmem_ready = rdy;
    #1;
  endtask

  task automatic quiet();
    drive(5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (ctl !== C_NORMAL) begin
      errors++;
      $display("FAIL reset_ctl: got %b expected %b", ctl, C_NORMAL);
    end
    checks++;
    if (fsm_state !== RUN) begin
      errors++;
      $display("FAIL reset_state: got %0d expected %0d", fsm_state, RUN);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    // load to $9 in EX, ID reads rs = $9
    drive(5'd9, 5'd3, 1, 5'd9, 0, 0, 0, 0, 0);
    checks++;
    if (ctl !== C_LDUSE) begin
      errors++; $display("FAIL lu_rs: got %b expected %b", ctl, C_LDUSE);
    end
    quiet();
    checks++;
    if (ctl !== C_NORMAL) begin
      errors++; $display("FAIL lu_after: got %b expected %b", ctl, C_NORMAL);
    end
    // match on rt
    drive(5'd1, 5'd17, 1, 5'd17, 0, 0, 0, 0, 0);
    checks++;
    if (ctl !== C_LDUSE) begin
      errors++; $display("FAIL lu_rt: got %b expected %b", ctl, C_LDUSE);
    end
    // destination $zero never stalls
    drive(5'd0, 5'd0, 1, 5'd0, 0, 0, 0, 0, 0);
    checks++;
    if (ctl !== C_NORMAL) begin
      errors++; $display("FAIL lu_zero: got %b expected %b", ctl, C_NORMAL);
    end
    // not a load
    drive(5'd9, 5'd9, 0, 5'd9, 0, 0, 0, 0, 0);
    checks++;
    if (ctl !== C_NORMAL) begin
      errors++; $display("FAIL lu_noload: got %b expected %b", ctl, C_NORMAL);
    end
    // load, no register match
    drive(5'd4, 5'd5, 1, 5'd6, 0, 0, 0, 0, 0);
    checks++;
    if (ctl !== C_NORMAL) begin
      errors++; $display("FAIL lu_nomatch: got %b expected %b", ctl, C_NORMAL);
    end
  endtask

  task automatic test_branch();
    drive(5'd0, 5'd0, 0, 5'd0, 1, 1, 0, 0, 0);
    checks++;
    if (ctl !== C_BRANCH) begin
      errors++; $display("FAIL br_taken: got %b expected %b", ctl, C_BRANCH);
    end
    quiet();
    checks++;
    if (ctl !== C_NORMAL) begin
      errors++; $display("FAIL br_after: got %b expected %b", ctl, C_NORMAL);
    end
    drive(5'd0, 5'd0, 0, 5'd0, 1, 0, 0, 0, 0);
    checks++;
    if (ctl !== C_NORMAL) begin
      errors++; $display("FAIL br_nottaken: got %b expected %b", ctl, C_NORMAL);
    end
    // zero-wait store with taken branch: advances, request visible
    drive(5'd0, 5'd0, 0, 5'd0, 1, 1, 0, 1, 1);
    checks++;
    if (ctl !== C_BR_MEM) begin
      errors++; $display("FAIL br_zero_wait: got %b expected %b", ctl, C_BR_MEM);
    end
  endtask

  task automatic test_mem_wait();
    logic [11:0] exp_ctl [4] = '{C_FREEZE, C_FREEZE, C_FREEZE, C_MEMADV};
    logic [1:0]  exp_st  [4] = '{RUN, MEM_WAIT, MEM_WAIT, MEM_WAIT};
    for (int i = 0; i < 4; i++) begin
      drive(5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, (i == 3));
      checks++;
      if (ctl !== exp_ctl[i]) begin
        errors++;
        $display("FAIL mw_ctl[%0d]: got %b expected %b", i, ctl, exp_ctl[i]);
      end
      checks++;
      if (fsm_state !== exp_st[i]) begin
        errors++;
        $display("FAIL mw_state[%0d]: got %0d expected %0d", i, fsm_state, exp_st[i]);
      end
    end
    quiet();
    checks++;
    if (fsm_state !== RUN || ctl !== C_NORMAL) begin
      errors++;
      $display("FAIL mw_return: got state %0d ctl %b expected state 0 ctl %b",
               fsm_state, ctl, C_NORMAL);
    end
  endtask

  task automatic test_branch_loaduse();
    drive(5'd9, 5'd2, 1, 5'd9, 1, 1, 0, 0, 0);
    checks++;
    if (ctl !== C_BRANCH) begin
      errors++; $display("FAIL br_lu: got %b expected %b", ctl, C_BRANCH);
    end
  endtask

  task automatic test_branch_in_wait();
    logic [11:0] exp_ctl [4] = '{C_FREEZE, C_FREEZE, C_FREEZE, C_BR_MEM};
    for (int i = 0; i < 4; i++) begin
      drive(5'd0, 5'd0, 0, 5'd0, 1, 1, 1, 0, (i == 3));
      checks++;
      if (ctl !== exp_ctl[i]) begin
        errors++;
        $display("FAIL brw_ctl[%0d]: got %b expected %b", i, ctl, exp_ctl[i]);
      end
    end
    quiet();
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (stall_cycles !== 32'd3 || flush_events !== 32'd1 || loaduse_events !== 32'd0) begin
      errors++;
      $display("FAIL perf_seq: got %0d/%0d/%0d expected 3/1/0",
               stall_cycles, flush_events, loaduse_events);
    end
`endif
  endtask

  task automatic test_reset_mid_wait();
    drive(5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 0);
    drive(5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 0);
    checks++;
    if (fsm_state !== MEM_WAIT) begin
      errors++; $display("FAIL rmw_pre: got %0d expected %0d", fsm_state, MEM_WAIT);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || fsm_state !== RUN) begin
      errors++;
      $display("FAIL rmw_abandon: got req %b state %0d expected req 0 state 0",
               dmem_req, fsm_state);
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (stall_cycles !== 32'd0 || flush_events !== 32'd0 || loaduse_events !== 32'd0) begin
      errors++;
      $display("FAIL rmw_perf: got %0d/%0d/%0d expected 0/0/0",
               stall_cycles, flush_events, loaduse_events);
    end
`endif
    quiet();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_timeout();
    // RUN freeze cycle, then TO wait cycles, then TRAP
    drive(5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 0);
    checks++;
    if (ctl !== C_FREEZE || fsm_state !== RUN) begin
      errors++; $display("FAIL to_entry: got %b/%0d expected %b/0", ctl, fsm_state, C_FREEZE);
    end
    for (int i = 0; i < TO; i++) begin
      drive(5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 0);
      checks++;
      if (ctl !== C_FREEZE || fsm_state !== MEM_WAIT) begin
        errors++;
        $display("FAIL to_wait[%0d]: got %b/%0d expected %b/1", i, ctl, fsm_state, C_FREEZE);
      end
    end
    drive(5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 0);
    checks++;
    if (ctl !== C_TRAP || fsm_state !== TRAP) begin
      errors++; $display("FAIL to_trap: got %b/%0d expected %b/2", ctl, fsm_state, C_TRAP);
    end
    // sticky: ready, branch, load-use all ignored
    drive(5'd9, 5'd0, 1, 5'd9, 1, 1, 1, 0, 1);
    drive(5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0);
    checks++;
    if (ctl !== C_TRAP || fsm_state !== TRAP) begin
      errors++; $display("FAIL to_sticky: got %b/%0d expected %b/2", ctl, fsm_state, C_TRAP);
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (stall_cycles !== 32'd5 || flush_events !== 32'd0 || loaduse_events !== 32'd0) begin
      errors++;
      $display("FAIL to_perf: got %0d/%0d/%0d expected 5/0/0",
               stall_cycles, flush_events, loaduse_events);
    end
`endif
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (trap !== 1'b0 || ctl !== C_NORMAL) begin
      errors++; $display("FAIL to_clear: got trap %b ctl %b expected 0 %b", trap, ctl, C_NORMAL);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_branch_loaduse();
    do_reset();
    test_branch_in_wait();
    test_reset_mid_wait();
    do_reset();
    test_timeout();
    quiet();
    checks++;
    if (ctl !== C_NORMAL || fsm_state !== RUN) begin
      errors++; $display("FAIL final_run: got %b/%0d expected %b/0", ctl, fsm_state, C_NORMAL);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // watchdog
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central pipeline sequencer for the 5-stage MIPS core. Drives enable and flush for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Detects load-use hazards and resolves taken branches at the MEM stage. Holds the whole pipeline while a multi-cycle data-memory access completes, and traps on a memory timeout.

## Interface
Parameters:
- TIMEOUT, 255: maximum MEM_WAIT cycles before trap (1..65535)
- CNT_W, 32: width of performance counters

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- ex_mem_read  in  1  instruction in EX is a load
- ex_rt_or_rd  in  5  destination register of instruction in EX
- mem_branch  in  1  EX/MEM o_branch
- mem_zero  in  1  EX/MEM o_ALU_zero_flag
- mem_mem_read  in  1  EX/MEM o_mem_read
- mem_mem_write  in  1  EX/MEM o_mem_write
- dmem_ready  in  1  data memory completes the access this cycle
- dmem_req  out  1  data memory access request
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register load enables
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  load a bubble (all control bits 0)
- pc_sel_branch  out  1  PC loads EX/MEM o_next instead of PC+4
- trap  out  1  sticky memory-timeout error

## Operation
- FSM states: RUN, MEM_WAIT, TRAP. Reset state: RUN.
- mem_acc = mem_mem_read | mem_mem_write.
- dmem_req = mem_acc in RUN or MEM_WAIT. It is 0 in TRAP.
- RUN with mem_acc & !dmem_ready: next state MEM_WAIT. That cycle all enables = 0 and all flushes = 0 (full freeze).
- RUN with mem_acc & dmem_ready: zero-wait access. Normal advance.
- MEM_WAIT: full freeze until dmem_ready. On dmem_ready, that cycle advances normally and the next state is RUN.
- Wait counter clears on entry to MEM_WAIT and increments each MEM_WAIT cycle. When the counter reaches TIMEOUT without dmem_ready, next state is TRAP.
- TRAP: trap = 1, all enables = 0, dmem_req = 0. Exit only via rst_n.
- Taken branch: taken = mem_branch & mem_zero, evaluated only on an advancing cycle.
  - taken asserts pc_sel_branch, if_id_flush, id_ex_flush and ex_mem_flush for that cycle.
  - mem_wb_en stays 1, so the branch retires.
  - Branch penalty is 3 cycles.
- Load-use hazard: ex_mem_read & (ex_rt_or_rd != 0) & (ex_rt_or_rd == id_rs | ex_rt_or_rd == id_rt).
  - Response: pc_en = 0, if_id_en = 0, id_ex_flush = 1. Remaining stages advance.
- Priority: TRAP > memory freeze > taken branch > load-use. A branch suppresses a simultaneous load-use stall, because the flush kills the dependent instruction.
- Flush overrides enable: a flushed register loads a bubble while its enable is 1.
- Default (no event): all enables = 1, all flushes = 0, pc_sel_branch = 0.

## Timing
- All outputs are combinational from the current state and inputs. They are valid in the same cycle and sampled by the pipeline registers at the next rising clk.
- Only state, wait counter, trap and perf counters are registered.
- Reset (asynchronous assert, deassert synchronous to clk) sets state RUN, counter 0 and trap 0.
- Output values while in reset with quiet inputs: enables 1, flushes 0, dmem_req 0, pc_sel_branch 0, trap 0.
- A reset asserted mid-MEM_WAIT abandons the access immediately. dmem_req drops asynchronously.
- dmem_ready is ignored when dmem_req = 0.
- With TIMEOUT = N, TRAP is entered after exactly N wait cycles with no dmem_ready.

## Configuration
- HAZARD_PERF_CNT_EN defined: adds output ports stall_cycles [CNT_W-1:0], flush_events [CNT_W-1:0] and loaduse_events [CNT_W-1:0].
  - stall_cycles counts freeze cycles.
  - flush_events counts taken branches.
  - loaduse_events counts load-use stalls.
  - Counters saturate at all-ones, reset to 0, and are frozen in TRAP.
- Not defined: these ports and counters do not exist. All other behaviour is identical.

## Structure
- Shared package pipeline_pkg:
  - state enum (RUN, MEM_WAIT, TRAP)
  - REG_ADDR_W = 5
  - bubble encoding constant
- Sub-module hazard_detect: purely combinational load-use compare, ports id_rs, id_rt, ex_mem_read, ex_rt_or_rd and output load_use.

## Test plan
- Load to $t1 in EX, ID reads rs = $t1 -> one cycle of pc_en = 0, if_id_en = 0, id_ex_flush = 1, then all enables 1. Same with ex_rt_or_rd = 0 -> no stall.
- mem_branch = 1, mem_zero = 1 -> pc_sel_branch, if_id/id_ex/ex_mem_flush = 1 for one cycle. With mem_zero = 0 -> no flush.
- mem_mem_read = 1, dmem_ready low 3 cycles then high -> dmem_req 4 cycles, full freeze 3 cycles, advance on the 4th, state returns to RUN.
- TIMEOUT = 4, dmem_ready never asserts -> TRAP after 4 wait cycles, trap = 1 sticky, dmem_req = 0. rst_n low clears trap.
- Taken branch coincident with load-use -> flush only, no PC stall. Branch during MEM_WAIT -> deferred until dmem_ready.
- With HAZARD_PERF_CNT_EN, previous sequence -> stall_cycles = 3, flush_events = 1, loaduse_events = 0. Reset mid-MEM_WAIT -> counters 0, state RUN.
